// File: rtl/aes_add_round_key_stage.sv
// AES AddRoundKey stage sitting after MixColumns.
// XORs the round key onto the MixColumns result (rounds 0..NR-1) or onto the
// ShiftRows result (final round NR), tags each beat with its round index and
// buffers results in a 2-entry output FIFO with valid/ready on both sides.
// Optional build macro: ARK_BLOCK_COUNT_EN adds a 16-bit blk_count output that
// counts emitted final-round beats.
module aes_add_round_key_stage #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_first,
    input  logic [127:0]  in_mixed,
    input  logic [127:0]  in_shifted,
    input  logic [127:0]  in_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_state,
    output logic [RW-1:0] out_round,
    output logic          out_last
`ifdef ARK_BLOCK_COUNT_EN
    ,
    output logic [15:0]   blk_count
`endif
);

    localparam logic [RW-1:0] NR_IDX = RW'(NR);

    // The FIFO is organised as a head entry (drives out_* directly) and a tail
    // entry. Keeping out_* on the head registers means they hold their last
    // value when the buffer empties.
    logic [1:0]    count_q, count_d;
    logic [127:0]  head_state_q, head_state_d;
    logic [RW-1:0] head_round_q, head_round_d;
    logic          head_last_q, head_last_d;
    logic [127:0]  tail_state_q, tail_state_d;
    logic [RW-1:0] tail_round_q, tail_round_d;
    logic          tail_last_q, tail_last_d;
    logic [RW-1:0] r_q, r_d;

    logic [RW-1:0] idx;
    logic          is_final;
    logic [127:0]  new_state;
    logic          push;
    logic          pop;

    // Round index / data selection for the incoming beat.
    always_comb begin
        idx       = in_first ? '0 : r_q;
        is_final  = (idx == NR_IDX);
        new_state = is_final ? (in_shifted ^ in_key) : (in_mixed ^ in_key);
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_state = head_state_q;
    assign out_round = head_round_q;
    assign out_last  = head_last_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next-state for round counter and the two FIFO entries.
    always_comb begin
        r_d          = r_q;
        count_d      = count_q;
        head_state_d = head_state_q;
        head_round_d = head_round_q;
        head_last_d  = head_last_q;
        tail_state_d = tail_state_q;
        tail_round_d = tail_round_q;
        tail_last_d  = tail_last_q;

        if (push) begin
            r_d = is_final ? '0 : idx + RW'(1);
        end

        case (count_q)
            2'd0: begin
                if (push) begin
                    head_state_d = new_state;
                    head_round_d = idx;
                    head_last_d  = is_final;
                    count_d      = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_state_d = new_state;
                    head_round_d = idx;
                    head_last_d  = is_final;
                end else if (push) begin
                    tail_state_d = new_state;
                    tail_round_d = idx;
                    tail_last_d  = is_final;
                    count_d      = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                // Full: no push is possible, a pop promotes the tail.
                if (pop) begin
                    head_state_d = tail_state_q;
                    head_round_d = tail_round_q;
                    head_last_d  = tail_last_q;
                    count_d      = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    // State registers; reset flushes the FIFO and round counter immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= 2'd0;
            r_q          <= '0;
            head_state_q <= '0;
            head_round_q <= '0;
            head_last_q  <= 1'b0;
            tail_state_q <= '0;
            tail_round_q <= '0;
            tail_last_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            r_q          <= r_d;
            head_state_q <= head_state_d;
            head_round_q <= head_round_d;
            head_last_q  <= head_last_d;
            tail_state_q <= tail_state_d;
            tail_round_q <= tail_round_d;
            tail_last_q  <= tail_last_d;
        end
    end

`ifdef ARK_BLOCK_COUNT_EN
    logic [15:0] blk_count_q, blk_count_d;

    // Count completed ciphertext beats leaving the stage, wrapping at 16 bits.
    always_comb begin
        blk_count_d = blk_count_q;
        if (pop && head_last_q) begin
            blk_count_d = blk_count_q + 16'd1;
        end
    end

    // Block counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count_q <= 16'd0;
        end else begin
            blk_count_q <= blk_count_d;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: doc/aes_add_round_key_stage.md
Name: aes_add_round_key_stage

Overview:
- Registered AddRoundKey stage directly downstream of the MixColumns block in the AES encryption datapath.
- XORs the current round key onto either the MixColumns result (rounds 0..NR-1) or the ShiftRows result (final round NR, where MixColumns is bypassed).
- Tracks the round index internally and tags each output beat with it.
- A 2-entry output buffer with valid/ready handshakes on both sides sustains 1 beat/cycle under backpressure.

Parameters:
- NR, 10, number of AES rounds (10/12/14 for AES-128/192/256).
- RW, 4, round-index width; must satisfy 2^RW > NR.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_first  input  1  beat is round 0 (initial key whitening); restarts sequence.
- in_mixed  input  128  MixColumns output; carries plaintext on round 0 beats.
- in_shifted  input  128  ShiftRows output; used only on round NR.
- in_key  input  128  round key for this beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- out_state  output  128  state after AddRoundKey.
- out_round  output  RW  round index of this beat.
- out_last  output  1  beat is round NR (ciphertext).

Behaviour:
- Reset (async, rst_n=0): buffer empty, out_valid=0, out_state=0, out_round=0, out_last=0, round counter r=0, in_ready=1 after release.
- Accept when in_valid && in_ready; emit when out_valid && out_ready.
- Effective round idx = in_first ? 0 : r.
- Data rule: idx==NR -> out = in_shifted ^ in_key; otherwise out = in_mixed ^ in_key. Plain bitwise 128-bit XOR, no width change.
- Counter update on accept: idx==NR -> r=0, else r=idx+1. No change when no accept.
- A round-0 beat with in_first=0 when r==0 is still treated as round 0.
- The buffer is a 2-entry FIFO holding {state, round, last}; in_ready = (count<2), driven from registered count only, with no combinational path from out_ready.
- Latency: a beat accepted at edge N is visible on out_* after edge N when the FIFO is empty; otherwise it follows older entries in order.
- Simultaneous push and pop: count is unchanged, data order is preserved; at count==2 no push occurs.
- Empty: out_valid=0 and out_* hold their last values; reset values are held if nothing has been emitted.
- Back-to-back: with out_ready=1 constantly, 1 beat/cycle throughput with no bubbles.
- out_* are stable while out_valid && !out_ready.
- in_first mid-sequence aborts the current block: the beat is round 0, r becomes 1, and already-buffered beats still drain unchanged.
- Reset mid-operation flushes the FIFO and r immediately.

Optional Feature:
- Macro ARK_BLOCK_COUNT_EN.
- When defined: adds output port blk_count (16 bits). It resets to 0 and increments, wrapping at 0xFFFF->0, on each out handshake with out_last=1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Round 0: in_first=1, in_mixed=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c -> one cycle later out_state=193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, out_last=0.
- Middle round (r=1): in_mixed=046681e5e0cb199a48f8d37a2806264c, in_key=a0fafe1788542cb123a339392a6c7605 -> out_state=a49c7ff2689f352b6b5bea43026a5049, out_round=1.
- Final round (r=10): in_shifted=e9317db5cb322c723d2e895faf090794, in_mixed=all-ones, in_key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> out_state=3925841d02dc09fbdc118597196a0b32, out_last=1; next beat has out_round=0 if in_first=0.
- Backpressure: hold out_ready=0 and push 3 beats -> in_ready drops after 2 accepts and the third is held. Release out_ready -> beats emerge in order, 1/cycle, with no loss or duplication.
- Restart/reset: assert in_first at r=5 -> beat tagged round 0 and next beat tagged 1. Pulse rst_n=0 with 2 beats buffered -> out_valid=0 immediately and r=0.
- ARK_BLOCK_COUNT_EN: run 3 full NR=10 blocks -> blk_count=3. Preload to 0xFFFF and complete 1 block -> blk_count=0.
